range_stats: RTL
================

# range_stats

Parametrised successor to the team's range-finding block: tracks the minimum, maximum and range of a framed sample stream, with a selectable signed/unsigned mode, a per-sample qualifier, a saturating sample counter and a completion pulse. It sits between the `ui_in`/`uio_in` pins and the `uo_out`/`uio_out` result pins of the top-level wrapper. It replaces the fixed 8-bit, unsigned-only, range-only function.

## Interface
Parameters:
- `WIDTH`, 8, sample and result width in bits (≥2)
- `CNT_W`, 8, sample-counter width in bits (≥2)
- `SIGNED`, 0, 0 = unsigned compare, 1 = two's-complement compare

Ports:
- `clk` in 1: single clock; all state changes on the rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `data_in` in WIDTH: sample.
- `go` in 1: start session; `data_in` on this cycle is sample #1 unconditionally.
- `finish` in 1: end session; `data_in` on this cycle is included if `sample_en`=1.
- `sample_en` in 1: qualifies `data_in` during RUN and on the finish cycle.
- `min_out` out WIDTH: minimum of the last completed session.
- `max_out` out WIDTH: maximum of the last completed session.
- `range_out` out WIDTH: `max_out` − `min_out`, always treated as unsigned.
- `count_out` out CNT_W: accepted samples in the last session, saturating.
- `done` out 1: one-cycle pulse when the results above update.
- `busy` out 1: high while in RUN.
- `error` out 1: high while in ERROR.
- `overflow` out 1: the counter saturated during the last completed session.

## Operation
- FSM has three states: IDLE, RUN, ERROR. All outputs are registered.
- IDLE:
  - `go`=1, `finish`=0 → RUN. The running min and max load `data_in`; the running count loads 1.
  - `go`=1, `finish`=1 → ERROR.
  - `finish`=1 alone → ERROR.
  - Otherwise stay in IDLE.
- RUN:
  - `go`=1, with any value of `finish` → ERROR. The session is discarded.
  - `finish`=1 → IDLE. The finish-cycle sample (if `sample_en`) is merged first. The merged min, max, range and count are then written to the result registers; `overflow_out` takes the sticky session flag and `done` pulses.
  - Otherwise, if `sample_en`=1: min = lesser(min, `data_in`), max = greater(max, `data_in`), count += 1.
- ERROR:
  - `go`=1, `finish`=0 → RUN; this starts a new session as from IDLE.
  - Otherwise stay in ERROR.
- Comparisons use `SIGNED` to select `$signed` or unsigned ordering.
- `range_out` is computed modulo 2^WIDTH. It always fits: it is ≤ 2^WIDTH−1 in both modes.
- A single-sample session gives min = max = sample, range 0, count 1.
- Counter saturation: the count holds at 2^CNT_W−1 and the session overflow flag sets. The flag clears on the next `go`.
- Result registers and `overflow` hold their values through IDLE, ERROR and the whole of the next RUN. They change only on a successful finish.

## Timing
- Reset (`rst_n`=0, takes effect immediately):
  - FSM goes to IDLE.
  - `min_out`, `max_out`, `range_out`, `count_out` = 0.
  - `done`, `busy`, `error`, `overflow` = 0.
  - Running registers = 0.
- Reset asserted mid-RUN aborts the session with no `done`. A `finish` after reset release is an error.
- `busy` rises on the cycle after the `go` edge and falls on the cycle after the `finish` edge.
- Latency from the finish edge to valid results is 1 cycle. `done` is high for exactly that cycle, coincident with the new result values.
- `error` rises on the cycle after the offending edge. It falls on the cycle after an accepted `go`.
- A `go` on the cycle immediately after a finish is accepted: the FSM is already in IDLE. Back-to-back sessions therefore need no idle gap.
- `sample_en` is ignored in IDLE and ERROR, and on the `go` cycle.

## Test plan
- **Unsigned session** (WIDTH=8, SIGNED=0, `sample_en`=1): go with 0x10, then 0x40, 0x05, 0x22, then finish with 0x30.
  - Next cycle: min 0x05, max 0x40, range 0x3B, count 5, `done`=1 for one cycle, `busy`=0.
- **Signed session** (SIGNED=1): go with 0x7F, then 0x80, finish with 0x00.
  - Result: min 0x80, max 0x7F, range 0xFF, count 3.
  - The same stimulus with SIGNED=0 gives min 0x00, max 0x80, range 0x80.
- **Qualifier**: go with 0x20, then 0xFF with `sample_en`=0, then finish with 0x10 and `sample_en`=1.
  - Result: min 0x10, max 0x20, range 0x10, count 2.
- **Protocol errors**:
  - `finish` in IDLE → `error`=1 next cycle, results unchanged, no `done`.
  - `go`+`finish` together → `error`=1.
  - `go` during RUN → `error`=1, `busy`=0.
  - A following lone `go` → `error`=0, `busy`=1.
- **Saturation** (CNT_W=3): go plus 9 more samples, then finish.
  - Result: count 7, `overflow`=1.
  - The next 2-sample session clears it to count 2, `overflow`=0.
- **Reset mid-RUN**: drop `rst_n` after 3 samples of a session that followed a completed one.
  - All outputs are 0 immediately, with no `done`.
  - After release, `finish` → `error`=1.

Source files
------------

// File: rtl/range_stats.sv
// Framed min/max/range tracker with signed or unsigned ordering, a per-sample qualifier,
// a saturating sample counter and a one-cycle completion pulse.
module range_stats #(
  parameter int WIDTH  = 8,
  parameter int CNT_W  = 8,
  parameter int SIGNED = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] data_in,
  input  logic             go,
  input  logic             finish,
  input  logic             sample_en,
  output logic [WIDTH-1:0] min_out,
  output logic [WIDTH-1:0] max_out,
  output logic [WIDTH-1:0] range_out,
  output logic [CNT_W-1:0] count_out,
  output logic             done,
  output logic             busy,
  output logic             error,
  output logic             overflow
);

  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_ERROR} state_t;

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_t           state, state_next;
  logic [WIDTH-1:0] run_min, run_max;
  logic [CNT_W-1:0] run_cnt;
  logic             run_ovf;

  logic             start, commit, merge, cnt_sat;
  logic [WIDTH-1:0] merged_min, merged_max;
  logic [CNT_W-1:0] merged_cnt;
  logic             merged_ovf;

  function automatic logic less_than(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    if (SIGNED != 0) return $signed(a) < $signed(b);
    else             return a < b;
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    start      = 1'b0;
    commit     = 1'b0;
    case (state)
      ST_IDLE: begin
        if (go && !finish) begin
          state_next = ST_RUN;
          start      = 1'b1;
        end else if (go || finish) begin
          state_next = ST_ERROR;
        end
      end
      ST_RUN: begin
        if (go) begin
          state_next = ST_ERROR;
        end else if (finish) begin
          state_next = ST_IDLE;
          commit     = 1'b1;
        end
      end
      ST_ERROR: begin
        if (go && !finish) begin
          state_next = ST_RUN;
          start      = 1'b1;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // Running values with the current cycle's sample folded in; also used as the finish-cycle result.
  always_comb begin
    merge      = (state == ST_RUN) && !go && sample_en;
    cnt_sat    = (run_cnt == CNT_MAX);
    merged_min = (merge && less_than(data_in, run_min)) ? data_in : run_min;
    merged_max = (merge && less_than(run_max, data_in)) ? data_in : run_max;
    merged_cnt = (merge && !cnt_sat) ? run_cnt + CNT_ONE : run_cnt;
    merged_ovf = run_ovf | (merge && cnt_sat);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      run_min <= '0;
      run_max <= '0;
      run_cnt <= '0;
      run_ovf <= 1'b0;
    end else if (start) begin
      run_min <= data_in;
      run_max <= data_in;
      run_cnt <= CNT_ONE;
      run_ovf <= 1'b0;
    end else if (state == ST_RUN) begin
      run_min <= merged_min;
      run_max <= merged_max;
      run_cnt <= merged_cnt;
      run_ovf <= merged_ovf;
    end
  end

  // Results only move on a successful finish; they hold through errors and later sessions.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      min_out   <= '0;
      max_out   <= '0;
      range_out <= '0;
      count_out <= '0;
      overflow  <= 1'b0;
      done      <= 1'b0;
      busy      <= 1'b0;
      error     <= 1'b0;
    end else begin
      done  <= commit;
      busy  <= (state_next == ST_RUN);
      error <= (state_next == ST_ERROR);
      if (commit) begin
        min_out   <= merged_min;
        max_out   <= merged_max;
        range_out <= merged_max - merged_min;
        count_out <= merged_cnt;
        overflow  <= merged_ovf;
      end
    end
  end

endmodule
